mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Control unit of the multicycle MIPS core, instantiated inside `top`; drives the datapath.
- Contains a Moore main-decoder FSM plus an ALU-function decoder.
- Produces `memwrite` and `iord`, which the system bench observes at memory, along with every other datapath enable and mux select.
- Inputs are the opcode and funct fields from the instruction register and the ALU zero flag.

Parameters:
- None. Instruction encodings are package constants.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU result == 0.
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write enable.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register-file write.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  write-back source: 0 = ALUOut, 1 = Data.
- alusrca  out  1  ALU A source: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B source: 00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation.
- pcen  out  1  PC enable = pcwrite | (branch & zero).
- state  out  4  current state encoding (debug).

Behaviour:
- State register updates on the rising edge of clk. `reset`==0 asynchronously forces FETCH.
- Outputs are Moore functions of state, with two exceptions:
  - pcen also depends on zero.
  - alucontrol also depends on funct.
- During and immediately after reset, outputs equal the FETCH decode. The datapath is held in reset concurrently.
- Every output not listed for a state is 0. Internal signals are pcwrite, branch and aluop[1:0].
- State encodings, outputs and transitions:
  - 0 FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1. Next: DECODE.
  - 1 DECODE: alusrcb=11, aluop=00. Next by op:
    - lw (100011) or sw (101011): MEMADR.
    - R-type (000000): RTYPEEX.
    - beq (000100): BEQEX.
    - addi (001000): ADDIEX.
    - j (000010): JEX.
    - any other op: FETCH (illegal op skipped; no write of any kind).
  - 2 MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=lw, else MEMWR.
  - 3 MEMRD: iord=1. Next: MEMWB.
  - 4 MEMWB: memtoreg=1, regwrite=1. Next: FETCH.
  - 5 MEMWR: iord=1, memwrite=1. Next: FETCH.
  - 6 RTYPEEX: alusrca=1, aluop=10. Next: RTYPEWB.
  - 7 RTYPEWB: regdst=1, regwrite=1. Next: FETCH.
  - 8 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  - 9 ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - 10 ADDIWB: regwrite=1. Next: FETCH.
  - 11 JEX: pcsrc=10, pcwrite=1. Next: FETCH.
  - 12–15: unreachable. Next: FETCH; outputs all 0.
- Cycles per instruction, FETCH through the last state inclusive:
  - lw 5.
  - sw, R-type, addi 4.
  - beq, j 3.
  - illegal op 2.
- ALU decode:
  - aluop 00 → alucontrol 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10 → decode funct:
    - add 100000 → 010.
    - sub 100010 → 110.
    - and 100100 → 000.
    - or 100101 → 001.
    - slt 101010 → 111.
    - unknown funct → 010 (never X).
  - aluop 11 → 010.
- op is held by the instruction register from DECODE onward. op is sampled only in DECODE and MEMADR.
- memwrite is high for exactly one cycle per sw and never otherwise.
- Reset asserted mid-instruction: immediate return to FETCH. No write strobe (memwrite, regwrite) may be high while reset==0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit, values above);
  - opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - aluop constants;
  - alucontrol constants.
- One sub-module, alu_decoder: aluop + funct → alucontrol, purely combinational.
- FSM and output decode stay in mc_controller.

Test Plan:
- Hold reset=0 for 2 cycles with op=100011 → state=0, irwrite=1, pcen=1, alusrcb=01, memwrite=0 throughout. Release reset → state sequence 0,1,2,3,4,0; iord=1 only in state 3; regwrite=1, memtoreg=1 only in state 4.
- op=101011 (sw) → states 0,1,2,5,0; memwrite=1 for exactly one cycle, in state 5, with iord=1.
- op=000000 with funct 101010, then 100010, then 111111 → alucontrol=111 in RTYPEEX; then 110; then 010. regdst=1, regwrite=1 in RTYPEWB each time.
- op=000100 (beq) with zero=1 → pcen=1 in state 8. Repeat with zero=0 → pcen=0. In both cases pcsrc=01 and the next state is 0.
- op=000010 (j) → states 0,1,11,0 with pcsrc=10, pcen=1 in state 11. op=111111 → states 0,1,0 with no write strobe.
- sw in state 5, assert reset=0 mid-cycle → state=0 and memwrite=0 immediately, without waiting for a clock edge. Release reset → normal FETCH resumes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Covers FSM states, opcode and funct fields, ALU op classes and ALU controls.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// ALU function decoder: maps the FSM's aluop class and the R-type funct field
// to an ALU operation. Purely combinational.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct falls back to add so the ALU never sees X.
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main-decoder FSM driving datapath enables
// and mux selects, plus the ALU function decoder.
module mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    // Reset lands in FETCH, so every write strobe drops without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StRtypeEx;
                    OP_BEQ:       state_d = StBeqEx;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJEx;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        case (state_q)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            StDecode: begin
                alusrcb = 2'b11;
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: begin
                iord = 1'b1;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            StRtypeWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StAddiWb: begin
                regwrite = 1'b1;
            end
            StJEx: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction vector table walked
// cycle by cycle, with expected outputs queued and compared each cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int bad    = 0;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       pcen;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         n;
        logic [3:0] st[5];
        logic [2:0] alu2;
        logic       pcen_last;
        string      name;
    } vec_t;

    outs_t exp_q[$];
    vec_t  tbl[$];

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Reference outputs for a given state, written from the state table.
    function automatic outs_t model(input logic [3:0] st, input logic [5:0] fn, input logic z);
        outs_t      o   = '0;
        logic [1:0] aop = 2'b00;
        logic       pw  = 1'b0;
        logic       br  = 1'b0;
        o.state = st;
        case (st)
            4'd0:  begin o.alusrcb = 2'b01; o.irwrite = 1'b1; pw = 1'b1; end
            4'd1:  o.alusrcb = 2'b11;
            4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd3:  o.iord = 1'b1;
            4'd4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            4'd6:  begin o.alusrca = 1'b1; aop = 2'b10; end
            4'd7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            4'd8:  begin o.alusrca = 1'b1; aop = 2'b01; o.pcsrc = 2'b01; br = 1'b1; end
            4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd10: o.regwrite = 1'b1;
            4'd11: begin o.pcsrc = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        case (aop)
            2'b01: o.alucontrol = 3'b110;
            2'b10: begin
                case (fn)
                    6'b100000: o.alucontrol = 3'b010;
                    6'b100010: o.alucontrol = 3'b110;
                    6'b100100: o.alucontrol = 3'b000;
                    6'b100101: o.alucontrol = 3'b001;
                    6'b101010: o.alucontrol = 3'b111;
                    default:   o.alucontrol = 3'b010;
                endcase
            end
            default: o.alucontrol = 3'b010;
        endcase
        o.pcen = pw | (br & z);
        return o;
    endfunction

    task automatic check_val(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // Queue the expectation for state st, let outputs settle, then compare.
    task automatic step(input logic [3:0] st, input string nm);
        outs_t act;
        outs_t exp;
        exp_q.push_back(model(st, funct, zero));
        #1;
        act = {state, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, pcen};
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s st%0d: got %h want %h", nm, st, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input int n,
                       input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4,
                       input logic [2:0] alu2, input logic pl, input string nm);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.n = n;
        v.st[0] = 4'd0; v.st[1] = 4'd1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        v.alu2 = alu2; v.pcen_last = pl; v.name = nm;
        tbl.push_back(v);
    endtask

    // Entered at a falling edge with the DUT in FETCH; leaves at the next FETCH.
    task automatic run_vec(input vec_t v);
        int mw = 0;
        op = v.op; funct = v.funct; zero = v.zero;
        for (int i = 0; i < v.n; i++) begin
            step(v.st[i], v.name);
            mw += int'(memwrite);
            if (i == 2) check_val({v.name, "_alu"}, int'(alucontrol), int'(v.alu2));
            if (i == v.n - 1 && v.st[i] == 4'd8)
                check_val({v.name, "_pcen"}, int'(pcen), int'(v.pcen_last));
            @(posedge clk);
            @(negedge clk);
        end
        check_val({v.name, "_memwrite_cycles"}, mw, (v.op == 6'b101011) ? 1 : 0);
    endtask

    initial begin
        add(6'b100011, 6'b000000, 1'b0, 5, 4'd2,  4'd3, 4'd4, 3'b010, 1'b0, "lw");
        add(6'b101011, 6'b000000, 1'b0, 4, 4'd2,  4'd5, 4'd0, 3'b010, 1'b0, "sw");
        add(6'b000000, 6'b101010, 1'b0, 4, 4'd6,  4'd7, 4'd0, 3'b111, 1'b0, "r_slt");
        add(6'b000000, 6'b100010, 1'b0, 4, 4'd6,  4'd7, 4'd0, 3'b110, 1'b0, "r_sub");
        add(6'b000000, 6'b111111, 1'b0, 4, 4'd6,  4'd7, 4'd0, 3'b010, 1'b0, "r_unk");
        add(6'b000000, 6'b100100, 1'b1, 4, 4'd6,  4'd7, 4'd0, 3'b000, 1'b0, "r_and");
        add(6'b000000, 6'b100101, 1'b0, 4, 4'd6,  4'd7, 4'd0, 3'b001, 1'b0, "r_or");
        add(6'b000000, 6'b100000, 1'b0, 4, 4'd6,  4'd7, 4'd0, 3'b010, 1'b0, "r_add");
        add(6'b000100, 6'b000000, 1'b1, 3, 4'd8,  4'd0, 4'd0, 3'b110, 1'b1, "beq_t");
        add(6'b000100, 6'b000000, 1'b0, 3, 4'd8,  4'd0, 4'd0, 3'b110, 1'b0, "beq_nt");
        add(6'b001000, 6'b000000, 1'b0, 4, 4'd9,  4'd10, 4'd0, 3'b010, 1'b0, "addi");
        add(6'b000010, 6'b000000, 1'b1, 3, 4'd11, 4'd0, 4'd0, 3'b010, 1'b0, "j");
        add(6'b111111, 6'b000000, 1'b1, 2, 4'd0,  4'd0, 4'd0, 3'b010, 1'b0, "illegal");

        reset = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0;
        @(negedge clk);
        step(4'd0, "reset_c0");
        @(posedge clk);
        @(negedge clk);
        step(4'd0, "reset_c1");
        reset = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k]);

        // sw interrupted in MEMWR by an asynchronous reset between clock edges.
        op = 6'b101011; funct = 6'd0; zero = 1'b0;
        step(4'd0, "sw_rst"); @(posedge clk); @(negedge clk);
        step(4'd1, "sw_rst"); @(posedge clk); @(negedge clk);
        step(4'd2, "sw_rst"); @(posedge clk); @(negedge clk);
        step(4'd5, "sw_rst");
        #2 reset = 1'b0;
        step(4'd0, "async_reset");
        check_val("async_reset_memwrite", int'(memwrite), 0);
        @(posedge clk);
        @(negedge clk);
        step(4'd0, "reset_hold");
        reset = 1'b1;
        run_vec(tbl[0]);
        step(4'd0, "final_fetch");

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
